// File: rtl/maker_pkt_rx_pkg.sv
// Shared NF2 constants, header word indices and the one's-complement add helper
// used by the maker UDP receive path.
package maker_pkt_rx_pkg;

   localparam logic [7:0]  DEF_IO_QUEUE_STAGE_NUM = 8'hff;
   localparam logic [15:0] ETHERTYPE_IP           = 16'h0800;
   localparam logic [7:0]  IPV4_VER_IHL           = 8'h45;
   localparam logic [7:0]  UDP_PROTO              = 8'd17;

   localparam logic [2:0]  WORD_ETH = 3'd2;
   localparam logic [2:0]  WORD_IP  = 3'd3;
   localparam logic [2:0]  WORD_SRC = 3'd4;
   localparam logic [2:0]  WORD_UDP = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_VERDICT
   } rx_state_t;

   // 16-bit one's-complement add with the end-around carry folded back in.
   function automatic logic [15:0] ocsum_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/maker_pkt_rx_ip_chksum_acc.sv
// IPv4 header checksum accumulator: clears, then folds up to four 16-bit lanes
// of a datapath word into a running one's-complement sum per cycle.
module ip_chksum_acc
   import maker_pkt_rx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        add,
   input  logic [63:0] data,
   input  logic [3:0]  lane_en,
   output logic [15:0] sum
);

   logic [15:0] acc;
   logic [15:0] s0, s1, s2, s3;

   always_comb begin
      s0 = lane_en[0] ? ocsum_add(acc, data[15:0])  : acc;
      s1 = lane_en[1] ? ocsum_add(s0,  data[31:16]) : s0;
      s2 = lane_en[2] ? ocsum_add(s1,  data[47:32]) : s1;
      s3 = lane_en[3] ? ocsum_add(s2,  data[63:48]) : s2;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (add) begin
         acc <= s3;
      end
   end

   assign sum = acc;

endmodule

// File: rtl/maker_pkt_rx.sv
// Inline snoop on the NF2 datapath: forwards words with one register stage and
// classifies each maker UDP packet (checksum, port match, runt) with stats.
module maker_pkt_rx
   import maker_pkt_rx_pkg::*;
#(
   parameter int         DATA_WIDTH         = 64,
   parameter int         CTRL_WIDTH         = DATA_WIDTH / 8,
   parameter logic [7:0] IO_QUEUE_STAGE_NUM = DEF_IO_QUEUE_STAGE_NUM,
   parameter int         CNT_WIDTH          = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic [15:0]           cfg_udp_dst_port,
   output logic                  pkt_match,
   output logic                  pkt_chksum_err,
   output logic                  pkt_runt,
   output logic [31:0]           last_src_ip,
   output logic [15:0]           last_udp_src_port,
   output logic [CNT_WIDTH-1:0]  num_match,
   output logic [CNT_WIDTH-1:0]  num_chksum_err
);

   rx_state_t   state;
   logic [2:0]  word_cnt;
   logic [15:0] ethertype;
   logic [7:0]  ver_ihl;
   logic [7:0]  proto;
   logic [31:0] src_ip;
   logic [15:0] udp_sport;
   logic [15:0] udp_dport;

   logic        hdr_word;
   logic        eop_word;
   logic        chk_clear;
   logic        chk_add;
   logic [3:0]  lane_en;
   logic [15:0] chk_sum;
   logic        ipv4_udp;
   logic        chk_ok;
   logic        port_hit;

   assign in_rdy   = out_rdy;
   assign hdr_word = in_wr && (in_ctrl == IO_QUEUE_STAGE_NUM);
   assign eop_word = in_wr && (in_ctrl != '0);

   assign chk_clear = hdr_word && ((state == ST_IDLE) || (state == ST_VERDICT));
   assign chk_add   = (state == ST_HDR) && in_wr && (in_ctrl == '0);

   // Header checksum covers ver_ihl..dst_ip: one lane of w2, all of w3/w4, top lane of w5.
   always_comb begin
      lane_en = '0;
      case (word_cnt)
         WORD_ETH: lane_en = 4'b0001;
         WORD_IP:  lane_en = 4'b1111;
         WORD_SRC: lane_en = 4'b1111;
         WORD_UDP: lane_en = 4'b1000;
         default:  lane_en = '0;
      endcase
   end

   ip_chksum_acc u_chksum (
      .clk     (clk),
      .reset   (reset),
      .clear   (chk_clear),
      .add     (chk_add),
      .data    (in_data[63:0]),
      .lane_en (lane_en),
      .sum     (chk_sum)
   );

   assign ipv4_udp = (ethertype == ETHERTYPE_IP) && (ver_ihl == IPV4_VER_IHL) && (proto == UDP_PROTO);
   assign chk_ok   = (chk_sum == 16'hffff);
   assign port_hit = (udp_dport == cfg_udp_dst_port);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data          <= '0;
         out_ctrl          <= '0;
         out_wr            <= 1'b0;
         state             <= ST_IDLE;
         word_cnt          <= '0;
         ethertype         <= '0;
         ver_ihl           <= '0;
         proto             <= '0;
         src_ip            <= '0;
         udp_sport         <= '0;
         udp_dport         <= '0;
         pkt_match         <= 1'b0;
         pkt_chksum_err    <= 1'b0;
         pkt_runt          <= 1'b0;
         last_src_ip       <= '0;
         last_udp_src_port <= '0;
         num_match         <= '0;
         num_chksum_err    <= '0;
      end else begin
         out_data       <= in_data;
         out_ctrl       <= in_ctrl;
         out_wr         <= in_wr;
         pkt_match      <= 1'b0;
         pkt_chksum_err <= 1'b0;
         pkt_runt       <= 1'b0;

         if (pkt_match && (num_match != '1))
            num_match <= num_match + CNT_WIDTH'(1);
         if (pkt_chksum_err && (num_chksum_err != '1))
            num_chksum_err <= num_chksum_err + CNT_WIDTH'(1);

         case (state)
            ST_IDLE: begin
               if (hdr_word) begin
                  state    <= ST_HDR;
                  word_cnt <= 3'd1;
               end
            end
            ST_HDR: begin
               if (eop_word) begin
                  pkt_runt <= 1'b1;
                  state    <= ST_IDLE;
               end else if (in_wr) begin
                  word_cnt <= word_cnt + 3'd1;
                  case (word_cnt)
                     WORD_ETH: begin
                        ethertype <= in_data[31:16];
                        ver_ihl   <= in_data[15:8];
                     end
                     WORD_IP:  proto  <= in_data[7:0];
                     WORD_SRC: src_ip <= in_data[47:16];
                     WORD_UDP: begin
                        udp_sport <= in_data[47:32];
                        udp_dport <= in_data[31:16];
                        state     <= ST_PAYLOAD;
                     end
                     default: ;
                  endcase
               end
            end
            // Verdict is registered on the eop edge so the pulse occupies the VERDICT cycle.
            ST_PAYLOAD: begin
               if (eop_word) begin
                  state          <= ST_VERDICT;
                  pkt_match      <= ipv4_udp && chk_ok && port_hit;
                  pkt_chksum_err <= ipv4_udp && !chk_ok;
                  if (ipv4_udp && chk_ok && port_hit) begin
                     last_src_ip       <= src_ip;
                     last_udp_src_port <= udp_sport;
                  end
               end
            end
            ST_VERDICT: begin
               if (hdr_word) begin
                  state    <= ST_HDR;
                  word_cnt <= 3'd1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maker_pkt_rx.sv
// Bench for maker_pkt_rx: table of packets, pulse scoreboard keyed by cycle,
// and a per-cycle pass-through check of the forwarded datapath.
module tb_maker_pkt_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        in_wr = 1'b0;
   logic        in_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy = 1'b1;
   logic [15:0] cfg_udp_dst_port = 16'h1234;
   logic        pkt_match, pkt_chksum_err, pkt_runt;
   logic [31:0] last_src_ip;
   logic [15:0] last_udp_src_port;
   logic [31:0] num_match, num_chksum_err;

   maker_pkt_rx #(
      .DATA_WIDTH         (64),
      .CTRL_WIDTH         (8),
      .IO_QUEUE_STAGE_NUM (8'hff),
      .CNT_WIDTH          (32)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .in_data           (in_data),
      .in_ctrl           (in_ctrl),
      .in_wr             (in_wr),
      .in_rdy            (in_rdy),
      .out_data          (out_data),
      .out_ctrl          (out_ctrl),
      .out_wr            (out_wr),
      .out_rdy           (out_rdy),
      .cfg_udp_dst_port  (cfg_udp_dst_port),
      .pkt_match         (pkt_match),
      .pkt_chksum_err    (pkt_chksum_err),
      .pkt_runt          (pkt_runt),
      .last_src_ip       (last_src_ip),
      .last_udp_src_port (last_udp_src_port),
      .num_match         (num_match),
      .num_chksum_err    (num_chksum_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ethertype;
      logic [7:0]  ver_ihl;
      logic [7:0]  proto;
      logic [31:0] src_ip;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [15:0] cfg;
      logic [15:0] chk_xor;
      int          runt_at;
      int          abort_at;
      int          npay;
      bit          gaps;
      bit          b2b;
      logic [2:0]  exp_pulse;   // {match, chksum_err, runt}
      bit          chk_cnt;
      logic [31:0] exp_nm;
      logic [31:0] exp_ne;
      logic [31:0] exp_src;
      logic [15:0] exp_sport;
   } vec_t;

   typedef struct {
      int         due;
      logic [2:0] p;
   } exp_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   exp_t        sbq[$];
   logic [72:0] ptq[$];
   vec_t        vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      ptq.push_back(reset ? 73'd0 : {in_wr, in_ctrl, in_data});
   end

   always @(negedge clk) begin
      logic [2:0]  ep;
      logic [72:0] pt;
      ep = 3'b000;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         ep = sbq[0].p;
         void'(sbq.pop_front());
      end
      check("pulses", {61'd0, pkt_match, pkt_chksum_err, pkt_runt}, {61'd0, ep});
      if (ptq.size() > 0) begin
         pt = ptq.pop_front();
         check("passthru", {out_wr, out_ctrl, out_data}, pt);
      end
      check("in_rdy", {63'd0, in_rdy}, {63'd0, out_rdy});
   end

   task automatic drive(input logic wr, input logic [7:0] ctrl, input logic [63:0] data, input logic rst);
      @(posedge clk);
      #1;
      in_wr   = wr;
      in_ctrl = ctrl;
      in_data = data;
      reset   = rst;
      out_rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 64'd0, 1'b0);
   endtask

   function automatic logic [15:0] hdr_chksum(input vec_t v, input logic [31:0] dst);
      logic [31:0] s;
      s = {16'd0, v.ver_ihl, 8'h00} + 32'h002e + 32'h0001 + 32'h4000 + {16'd0, 8'h40, v.proto}
        + {16'd0, v.src_ip[31:16]} + {16'd0, v.src_ip[15:0]} + {16'd0, dst[31:16]} + {16'd0, dst[15:0]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return ~s[15:0];
   endfunction

   task automatic send_pkt(input vec_t v);
      logic [63:0] w[6];
      logic [31:0] dst;
      logic [15:0] chk;
      logic [7:0]  ctrl;
      logic        rst;
      dst  = 32'hc0a80002;
      chk  = hdr_chksum(v, dst) ^ v.chk_xor;
      w[0] = 64'h0000_0005_0001_0048;
      w[1] = {48'h0011_2233_4455, 16'h6677};
      w[2] = {32'h8899_aabb, v.ethertype, v.ver_ihl, 8'h00};
      w[3] = {16'h002e, 16'h0001, 16'h4000, 8'h40, v.proto};
      w[4] = {chk, v.src_ip, dst[31:16]};
      w[5] = {dst[15:0], v.sport, v.dport, 16'h001a};
      for (int k = 0; k < 6; k++) begin
         ctrl = (k == 0) ? 8'hff : ((v.runt_at != 0 && k == v.runt_at) ? 8'h08 : 8'h00);
         rst  = (k == v.abort_at);
         drive(1'b1, ctrl, w[k], rst);
         if (rst) begin
            idle(1);
            return;
         end
         if (v.runt_at != 0 && k == v.runt_at) begin
            sbq.push_back('{due: cyc + 1, p: v.exp_pulse});
            return;
         end
         if (v.gaps) drive(1'b0, 8'hff, {$urandom, $urandom}, 1'b0);
      end
      for (int p = 0; p < v.npay; p++) begin
         drive(1'b1, (p == v.npay - 1) ? 8'h80 : 8'h00, {$urandom, $urandom}, 1'b0);
         if (p == v.npay - 1) begin
            if (v.exp_pulse != 3'b000) sbq.push_back('{due: cyc + 1, p: v.exp_pulse});
         end else if (v.gaps) begin
            drive(1'b0, 8'h00, {$urandom, $urandom}, 1'b0);
         end
      end
   endtask

   function automatic vec_t base(input logic [15:0] sport, input logic [2:0] pulse);
      vec_t v;
      v.ethertype = 16'h0800; v.ver_ihl = 8'h45; v.proto = 8'd17;
      v.src_ip = 32'hc0a80001; v.sport = sport; v.dport = 16'h1234; v.cfg = 16'h1234;
      v.chk_xor = 16'h0000; v.runt_at = 0; v.abort_at = -1; v.npay = 3;
      v.gaps = 1'b0; v.b2b = 1'b0; v.exp_pulse = pulse;
      v.chk_cnt = 1'b0; v.exp_nm = 0; v.exp_ne = 0; v.exp_src = 0; v.exp_sport = 0;
      return v;
   endfunction

   function automatic vec_t with_cnt(input vec_t v, input logic [31:0] nm, input logic [31:0] ne,
                                     input logic [31:0] src, input logic [15:0] sp);
      vec_t r;
      r = v; r.chk_cnt = 1'b1; r.exp_nm = nm; r.exp_ne = ne; r.exp_src = src; r.exp_sport = sp;
      return r;
   endfunction

   initial begin
      vec_t v;
      // good match
      vecs.push_back(with_cnt(base(16'h5000, 3'b100), 1, 0, 32'hc0a80001, 16'h5000));
      // bad checksum, different src port must not reach last_*
      v = base(16'h5001, 3'b010); v.chk_xor = 16'h0001;
      vecs.push_back(with_cnt(v, 1, 1, 32'hc0a80001, 16'h5000));
      // port miss
      v = base(16'h5009, 3'b000); v.cfg = 16'h4321; vecs.push_back(v);
      // runt on w3, then good back-to-back, then good in VERDICT cycle
      v = base(16'h5009, 3'b001); v.runt_at = 3; vecs.push_back(v);
      v = base(16'h5002, 3'b100); v.b2b = 1'b1; vecs.push_back(v);
      v = base(16'h5003, 3'b100); v.b2b = 1'b1; v.src_ip = 32'hc0a80003; v.npay = 1;
      vecs.push_back(with_cnt(v, 3, 1, 32'hc0a80003, 16'h5003));
      // non-IPv4/UDP packets
      v = base(16'h5009, 3'b000); v.ethertype = 16'h0806; vecs.push_back(v);
      v = base(16'h5009, 3'b000); v.ver_ihl = 8'h46; vecs.push_back(v);
      v = base(16'h5009, 3'b000); v.proto = 8'd6; vecs.push_back(v);
      v = base(16'h5009, 3'b001); v.runt_at = 1; vecs.push_back(v);
      // idle bubbles (with hdr-looking ctrl) between every word
      v = base(16'h5004, 3'b100); v.gaps = 1'b1;
      vecs.push_back(with_cnt(v, 4, 1, 32'hc0a80001, 16'h5004));
      // reset on w4 aborts, then counters restart from zero
      v = base(16'h5009, 3'b000); v.abort_at = 4; vecs.push_back(v);
      v = base(16'h5005, 3'b100); v.src_ip = 32'hc0a80007;
      vecs.push_back(with_cnt(v, 1, 0, 32'hc0a80007, 16'h5005));
      v = base(16'h5006, 3'b010); v.chk_xor = 16'h8000; v.gaps = 1'b1; v.npay = 1;
      vecs.push_back(with_cnt(v, 1, 1, 32'hc0a80007, 16'h5005));

      drive(1'b0, 8'h00, 64'd0, 1'b1);
      drive(1'b0, 8'h00, 64'd0, 1'b1);
      idle(2);
      check("rst_num_match", {32'd0, num_match}, 64'd0);
      check("rst_num_err", {32'd0, num_chksum_err}, 64'd0);
      check("rst_last_src", {32'd0, last_src_ip}, 64'd0);
      check("rst_last_sport", {48'd0, last_udp_src_port}, 64'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (!v.b2b) idle(3);
         cfg_udp_dst_port = v.cfg;
         send_pkt(v);
         if (v.chk_cnt) begin
            idle(4);
            check("num_match", {32'd0, num_match}, {32'd0, v.exp_nm});
            check("num_chksum_err", {32'd0, num_chksum_err}, {32'd0, v.exp_ne});
            check("last_src_ip", {32'd0, last_src_ip}, {32'd0, v.exp_src});
            check("last_sport", {48'd0, last_udp_src_port}, {48'd0, v.exp_sport});
         end
      end

      // saturation of num_match
      idle(2);
      force dut.num_match = 32'hffff_ffff;
      idle(1);
      release dut.num_match;
      idle(1);
      check("sat_preset", {32'd0, num_match}, 64'h0000_0000_ffff_ffff);
      cfg_udp_dst_port = 16'h1234;
      send_pkt(base(16'h5007, 3'b100));
      idle(4);
      check("sat_hold", {32'd0, num_match}, 64'h0000_0000_ffff_ffff);
      check("sat_last_sport", {48'd0, last_udp_src_port}, {48'd0, 16'h5007});
      idle(2);
      check("sb_drained", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
